// File: rtl/cla_seq_adder.sv
// Multi-cycle adder that time-shares one 4-bit carry-lookahead slice, LS nibble first.
// Optional subtract mode is enabled by defining CLA_SEQ_ADDER_SUB_EN (adds the SUB port).
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef CLA_SEQ_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

  logic             sub_sel;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       sum_nib;
  logic [4:0]       c;

`ifdef CLA_SEQ_ADDER_SUB_EN
  assign sub_sel = SUB;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so CIN is overridden rather than combined.
  assign b_in = sub_sel ? ~B : B;
  assign c_in = sub_sel ? 1'b1 : CIN;

  assign a_nib = a_cap[{cnt, 2'b00} +: 4];
  assign b_nib = b_cap[{cnt, 2'b00} +: 4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign g[gi]       = a_nib[gi] & b_nib[gi];
      assign p[gi]       = a_nib[gi] | b_nib[gi];
      assign sum_nib[gi] = a_nib[gi] ^ b_nib[gi] ^ c[gi];
    end
  endgenerate

  // Flattened lookahead: every carry depends only on G/P and the slice carry-in.
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state <= ST_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_cap <= '0;
      b_cap <= '0;
      S     <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            a_cap <= A;
            b_cap <= b_in;
            carry <= c_in;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          S[{cnt, 2'b00} +: 4] <= sum_nib;
          carry                <= c[4];
          if (cnt == CW'(NSLICE - 1)) begin
            COUT  <= c[4];
            OVF   <= c[3] ^ c[4];
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign READY = (state == ST_IDLE) || (state == ST_DONE);
  assign BUSY  = (state == ST_RUN);
  assign DONE  = (state == ST_DONE);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: vector table plus hand sequences for
// back-to-back starts, result holding and asynchronous reset mid-operation.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        ready, busy, done_o, cout, ovf;
  logic [15:0] s;

  cla_seq_adder #(.WIDTH(16)) dut (
    .CLK     (clk),
    .RESET_L (rst_n),
    .START   (start),
    .A       (a),
    .B       (b),
    .CIN     (cin),
`ifdef CLA_SEQ_ADDER_SUB_EN
    .SUB     (sub),
`endif
    .READY   (ready),
    .BUSY    (busy),
    .DONE    (done_o),
    .S       (s),
    .COUT    (cout),
    .OVF     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;
  logic last_cout = 1'b0;
  logic last_ovf  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One START pulse, then scramble inputs to prove only captured operands matter.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input logic vs, output int busy_cycles, output logic hold_ok,
                        output logic timed_out);
    a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    busy_cycles = 0;
    hold_ok = 1'b1;
    while (!done_o && busy_cycles < 20) begin
      if (busy) busy_cycles++;
      if (cout !== last_cout || ovf !== last_ovf) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    timed_out = !done_o;
    sub = 1'b0;
  endtask

  initial begin
    int          bc;
    logic        hold_ok, to;
    logic [16:0] model;
    int          done_cnt;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0});
`ifdef CLA_SEQ_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
`endif
    vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});

    // Reset state
    #12;
    chk("reset_ready", ready, 1); chk("reset_busy", busy, 0); chk("reset_done", done_o, 0);
    chk("reset_s", s, 0); chk("reset_cout", cout, 0); chk("reset_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, bc, hold_ok, to);
      $display("op %0d: A=%h B=%h CIN=%0d SUB=%0d -> S=%h COUT=%0d OVF=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, cout, ovf, bc);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_s", i), s, vecs[i].s);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].cout);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d_busy_cycles", i), bc, 4);
      chk($sformatf("v%0d_flags_held_in_run", i), hold_ok, 1);
      chk($sformatf("v%0d_ready_in_done", i), ready, 1);
      last_cout = vecs[i].cout;
      last_ovf  = vecs[i].ovf;
    end

    // DONE lasts one cycle, then results hold in IDLE
    @(posedge clk); #1;
    chk("idle_done_low", done_o, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_s", s, 16'h7FFF); chk("hold_cout", cout, 1); chk("hold_ovf", ovf, 1);
    chk("hold_ready", ready, 1); chk("hold_busy", busy, 0);

    // START held high with operands changing every cycle
    for (int j = 0; j < 15; j++) begin
      a = 16'h1000 + 16'(j) * 16'h0101;
      b = 16'(j) * 16'h0011;
      start = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b_done_c%0d", j), done_o, (j % 5 == 4) ? 1 : 0);
      if (j % 5 == 4) begin
        model = 17'(16'h1000 + 16'(j - 4) * 16'h0101) + 17'(16'(j - 4) * 16'h0011);
        $display("b2b op at edge %0d -> S=%h COUT=%0d", j - 4, s, cout);
        chk($sformatf("b2b_s_c%0d", j), s, model[15:0]);
        chk($sformatf("b2b_cout_c%0d", j), cout, model[16]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_ready", ready, 1); chk("b2b_end_busy", busy, 0); chk("b2b_end_done", done_o, 0);

    // Give COUT a non-zero value, then reset during the second RUN cycle
    run_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, bc, hold_ok, to);
    chk("pre_rst_cout", cout, 1);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-run -> S=%h COUT=%0d BUSY=%0d READY=%0d", s, cout, busy, ready);
    chk("rst_s", s, 0); chk("rst_cout", cout, 0); chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0); chk("rst_ready", ready, 1);
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    repeat (8) begin @(posedge clk); #1; if (done_o) done_cnt++; end
    chk("rst_no_done", done_cnt, 0);
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, bc, hold_ok, to);
    $display("post-reset op -> S=%h COUT=%0d OVF=%0d", s, cout, ovf);
    chk("post_rst_timeout", to, 0); chk("post_rst_s", s, 16'h1001);
    chk("post_rst_cout", cout, 0); chk("post_rst_busy_cycles", bc, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
